uart_tx_fsm: RTL and testbench

//   UART transmit engine: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
//   It is the transmit counterpart of the UART RX path and uses the same frame format and

---
 rtl/uart_tx_fsm.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_fsm.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: UART transmit engine.
// Each frame is a start bit, DATA_WIDTH data bits sent LSB first, an optional parity bit
// and one stop bit. Every line level is held for the latched prescale count of clk cycles.
// Ports:
//   clk, rst    - system clock and asynchronous active-high reset
//   P_DATA      - parallel payload, captured when a frame is accepted
//   Data_Valid  - request to send; accepted only in IDLE
//   PAR_EN      - append a parity bit (captured on accept)
//   PAR_TYP     - 0 even / 1 odd parity (captured on accept)
//   prescale    - clk cycles per bit, 0 treated as 1 (captured on accept)
//   TX_OUT      - registered serial line, idle high
//   busy        - registered, high while a frame is on the line
//   tx_done     - registered one-cycle pulse after the stop bit completes
module uart_tx_fsm #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic                  r_par_en;
  logic                  r_parity;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [CNT_W-1:0]      r_bit_cnt;

  logic [PRESCALE_W-1:0] w_prescale_eff;
  logic                  w_parity;
  logic                  w_last_edge;
  logic                  w_last_bit;

  // A zero prescale would never let the edge counter reach its terminal count.
  assign w_prescale_eff = (prescale == '0) ? PRESCALE_W'(1) : prescale;
  assign w_parity       = (^P_DATA) ^ PAR_TYP;
  assign w_last_edge    = (r_edge_cnt == (r_prescale - PRESCALE_W'(1)));
  assign w_last_bit     = (r_bit_cnt == CNT_W'(DATA_WIDTH - 1));

  // Control FSM, counters, shift register and line driver.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_shreg    <= '0;
      r_par_en   <= 1'b0;
      r_parity   <= 1'b0;
      r_prescale <= '0;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      r_done <= 1'b0;

      // Bit-period timing runs in every non-idle state.
      if (r_state != S_IDLE) begin
        if (w_last_edge) r_edge_cnt <= '0;
        else             r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          r_tx       <= 1'b1;
          r_busy     <= 1'b0;
          r_edge_cnt <= '0;
          r_bit_cnt  <= '0;
          if (Data_Valid) begin
            r_shreg    <= P_DATA;
            r_par_en   <= PAR_EN;
            r_parity   <= w_parity;
            r_prescale <= w_prescale_eff;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_START;
          end
        end

        S_START: begin
          if (w_last_edge) begin
            r_tx      <= r_shreg[0];
            r_shreg   <= r_shreg >> 1;
            r_bit_cnt <= '0;
            r_state   <= S_DATA;
          end
        end

        S_DATA: begin
          if (w_last_edge) begin
            if (w_last_bit) begin
              if (r_par_en) begin
                r_tx    <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_tx      <= r_shreg[0];
              r_shreg   <= r_shreg >> 1;
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
        end

        S_PARITY: begin
          if (w_last_edge) begin
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end
        end

        S_STOP: begin
          if (w_last_edge) begin
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        // Corrupted encodings fall back to an idle line.
        default: begin
          r_tx       <= 1'b1;
          r_busy     <= 1'b0;
          r_edge_cnt <= '0;
          r_bit_cnt  <= '0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign TX_OUT  = r_tx;
  assign busy    = r_busy;
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb_uart_tx_fsm: directed self-checking bench for uart_tx_fsm.
// Expected line levels per frame are hand-computed bit vectors (index 0 = start bit).
module tb_uart_tx_fsm;

  logic       clk;
  logic       rst;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [4:0] prescale;
  logic       TX_OUT;
  logic       busy;
  logic       tx_done;

  int n_cmp;
  int n_err;

  uart_tx_fsm #(.DATA_WIDTH(8), .PRESCALE_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .prescale   (prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Sends one frame and checks every cycle of it. lvl[i] is the level of line bit i,
  // p is the effective bit length. inj >= 0 pulses Data_Valid with other data at the
  // start of that line bit. hold leaves Data_Valid high after the accept edge.
  task automatic send_frame(input string name, input logic [7:0] d, input logic pe,
                            input logic pt, input logic [4:0] ps, input logic [10:0] lvl,
                            input int nb, input int p, input int inj, input logic hold);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; prescale = ps; Data_Valid = 1'b1;
    tick();
    Data_Valid = hold;
    for (int i = 0; i < nb; i++) begin
      for (int c = 0; c < p; c++) begin
        check($sformatf("%s bit%0d cyc%0d TX_OUT", name, i, c), TX_OUT, lvl[i]);
        check($sformatf("%s bit%0d cyc%0d busy", name, i, c), busy, 1'b1);
        check($sformatf("%s bit%0d cyc%0d tx_done", name, i, c), tx_done, 1'b0);
        if (i == inj && c == 0) begin
          Data_Valid = 1'b1; P_DATA = 8'h3C; PAR_EN = 1'b1; prescale = 5'd1;
          tick();
          Data_Valid = hold; P_DATA = 8'h3C;
        end else begin
          tick();
        end
      end
    end
    check({name, " end busy"}, busy, 1'b0);
    check({name, " end tx_done"}, tx_done, 1'b1);
    check({name, " end TX_OUT"}, TX_OUT, 1'b1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; P_DATA = 8'h00; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    prescale = 5'd0;
    #13;
    check("reset TX_OUT", TX_OUT, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset tx_done", tx_done, 1'b0);
    @(negedge clk); rst = 1'b0;
    tick(); tick();
    check("idle TX_OUT", TX_OUT, 1'b1);
    check("idle busy", busy, 1'b0);

    // 0xA5 even parity, P=8: 0,1,0,1,0,0,1,0,1,0,1
    send_frame("A5", 8'hA5, 1'b1, 1'b0, 5'd8, 11'b10101001010, 11, 8, -1, 1'b0);
    tick();
    check("A5 post tx_done", tx_done, 1'b0);
    check("A5 post busy", busy, 1'b0);

    // 0x00 no parity, P=16: 9 low bits then stop
    send_frame("00", 8'h00, 1'b0, 1'b0, 5'd16, 11'b01000000000, 10, 16, -1, 1'b0);
    tick();

    // 0x01 odd parity, P=4: parity bit 0
    send_frame("01", 8'h01, 1'b1, 1'b1, 5'd4, 11'b10000000010, 11, 4, -1, 1'b0);
    tick();

    // 0xFF, Data_Valid pulsed with 0x3C in data bit 3: frame unchanged, nothing queued
    send_frame("FF", 8'hFF, 1'b0, 1'b0, 5'd2, 11'b01111111110, 10, 2, 4, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("FF after idle%0d busy", k), busy, 1'b0);
      check($sformatf("FF after idle%0d TX_OUT", k), TX_OUT, 1'b1);
    end

    // Reset in data bit 3 of a 0x55 frame (that bit is 0 on the line)
    P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 5'd8; Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
    repeat (35) tick();
    check("pre-reset TX_OUT", TX_OUT, 1'b0);
    check("pre-reset busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midframe reset TX_OUT", TX_OUT, 1'b1);
    check("midframe reset busy", busy, 1'b0);
    check("midframe reset tx_done", tx_done, 1'b0);
    @(negedge clk); rst = 1'b0;
    tick();
    send_frame("55", 8'h55, 1'b0, 1'b0, 5'd8, 11'b01010101010, 10, 8, -1, 1'b0);
    tick();

    // prescale 0 -> 1 cycle per bit, back-to-back with Data_Valid held high
    send_frame("80a", 8'h80, 1'b1, 1'b0, 5'd0, 11'b11100000000, 11, 1, -1, 1'b1);
    send_frame("80b", 8'h80, 1'b1, 1'b0, 5'd0, 11'b11100000000, 11, 1, -1, 1'b0);
    tick();
    check("final busy", busy, 1'b0);
    check("final tx_done", tx_done, 1'b0);
    check("final TX_OUT", TX_OUT, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
